gate_exerciser: RTL

- Self-checking stimulus/response stage wrapped around basic_gates.
- Upstream, it drives the gate inputs a and b through every input combination, in order {a,b} = 00, 01, 10, 11.
- Downstream, it samples the six gate outputs after a programmable settle time and compares them against the expected truth table.
- It reports a mismatch count, a per-vector fail mask and a pass/done status, so gate checks run in hardware or in simulation without $monitor inspection.

---
 rtl/gate_exerciser_if.sv | 26 ++
 rtl/gate_exerciser.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/gate_exerciser_if.sv
`default_nettype none
// ============================================================================
// gate_exerciser_if : stimulus/response bundle between the exerciser and gates
// Rev 1.0
// ============================================================================
interface gate_exerciser_if;
  logic a;
  logic b;
  logic not_out;
  logic and_out;
  logic or_out;
  logic buff_out;
  logic xor_out;
  logic xnor_out;

  modport master (
    output a, b,
    input  not_out, and_out, or_out, buff_out, xor_out, xnor_out
  );

  modport slave (
    input  a, b,
    output not_out, and_out, or_out, buff_out, xor_out, xnor_out
  );
endinterface
`default_nettype wire

// File: rtl/gate_exerciser.sv
`default_nettype none
// ============================================================================
// gate_exerciser : sweeps {a,b} through 00..11 and checks six gate outputs
// Rev 1.0
// ============================================================================
module gate_exerciser #(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS         = 1,
  parameter int ERR_W         = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  gate_exerciser_if.master   gif,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_count,
  output logic [3:0]         fail_mask
);

  localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;

  localparam logic [1:0] C_IDLE   = 2'd0;
  localparam logic [1:0] C_SETTLE = 2'd1;
  localparam logic [1:0] C_CHECK  = 2'd2;
  localparam logic [1:0] C_DONE   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [1:0]        vec_q, vec_d;
  logic [LOOP_W-1:0] loop_q, loop_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        ab_q, ab_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [3:0]        mask_q, mask_d;

  logic [5:0]        w_expected;
  logic [5:0]        w_observed;
  logic              w_mismatch;
  logic [ERR_W-1:0]  w_err_inc;

  assign w_expected = {~ab_q[1], ab_q[1] & ab_q[0], ab_q[1] | ab_q[0],
                       ab_q[1], ab_q[1] ^ ab_q[0], ~(ab_q[1] ^ ab_q[0])};
  assign w_observed = {gif.not_out, gif.and_out, gif.or_out,
                       gif.buff_out, gif.xor_out, gif.xnor_out};
  assign w_mismatch = (w_observed != w_expected);
  // Saturate rather than wrap so a long failing run never reads as clean
  assign w_err_inc  = (err_q == {ERR_W{1'b1}}) ? err_q : err_q + ERR_W'(1);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    loop_d  = loop_q;
    cnt_d   = cnt_q;
    ab_d    = ab_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    mask_d  = mask_q;
    if (abort) begin
      state_d = C_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
      ab_d    = 2'b00;
    end else begin
      case (state_q)
        C_IDLE, C_DONE: begin
          if (start) begin
            err_d   = '0;
            mask_d  = '0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            vec_d   = 2'd0;
            loop_d  = '0;
            cnt_d   = '0;
            ab_d    = 2'b00;
            busy_d  = 1'b1;
            state_d = C_SETTLE;
          end
        end
        C_SETTLE: begin
          if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
            state_d = C_CHECK;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        C_CHECK: begin
          if (w_mismatch) begin
            err_d         = w_err_inc;
            mask_d[vec_q] = 1'b1;
          end
          if (vec_q == 2'd3 && loop_q == LOOP_W'(LOOPS - 1)) begin
            state_d = C_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            vec_d   = vec_q + 2'd1;
            if (vec_q == 2'd3) begin
              loop_d = loop_q + LOOP_W'(1);
            end
            ab_d    = vec_q + 2'd1;
            cnt_d   = '0;
            state_d = C_SETTLE;
          end
        end
        default: state_d = C_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= C_IDLE;
      vec_q   <= 2'd0;
      loop_q  <= '0;
      cnt_q   <= '0;
      ab_q    <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      loop_q  <= loop_d;
      cnt_q   <= cnt_d;
      ab_q    <= ab_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
    end
  end

  assign gif.a     = ab_q[1];
  assign gif.b     = ab_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_mask = mask_q;

endmodule
`default_nettype wire
